// File: rtl/tlc_using_sensor.sv
// -----------------------------------------------------------------------------
// tlc_using_sensor
//   Sensor-actuated traffic light controller for a two-road intersection.
//   Road 1 keeps green until road 2 requests service (and the reverse).
//   Every change of right-of-way goes through minimum green, yellow and all-red.
//   The lamps are a pure decode of the state register (Moore machine).
//
// Ports:
//   clk         : system clock, rising edge active
//   reset       : asynchronous, active-high reset (forces G1, timer 0)
//   x           : vehicle present on road 1 (sampled on clk rising edge)
//   y           : vehicle present on road 2 (sampled on clk rising edge)
//   r1, y1, g1  : road 1 red / yellow / green lamps
//   r2, y2, g2  : road 2 red / yellow / green lamps
//   o_dbg_state : current FSM state, for observation only
// -----------------------------------------------------------------------------
module tlc_using_sensor #(
  parameter int MIN_GREEN   = 3,
  parameter int MAX_GREEN   = 6,
  parameter int YELLOW_TIME = 2,
  parameter int ALL_RED     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       x,
  input  logic       y,
  output logic       r1,
  output logic       y1,
  output logic       g1,
  output logic       r2,
  output logic       y2,
  output logic       g2,
  output logic [2:0] o_dbg_state
);

  typedef enum logic [2:0] {
    S_G1  = 3'd0,
    S_Y1  = 3'd1,
    S_AR1 = 3'd2,
    S_G2  = 3'd3,
    S_Y2  = 3'd4,
    S_AR2 = 3'd5
  } state_t;

  // Thresholds are expressed as "timer value on the last cycle of the phase",
  // since the timer reads 0 on the first cycle of every state.
  localparam logic [7:0] C_MIN_M1 = 8'(MIN_GREEN - 1);
  localparam logic [7:0] C_MAX_M1 = 8'(MAX_GREEN - 1);
  localparam logic [7:0] C_YEL_M1 = 8'(YELLOW_TIME - 1);
  localparam logic [7:0] C_AR_M1  = 8'(ALL_RED - 1);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_timer;
  logic       w_min_ok;
  logic       w_max_ok;

  assign w_min_ok = (r_timer >= C_MIN_M1);
  assign w_max_ok = (r_timer >= C_MAX_M1);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_G1;
    end else begin
      r_state <= w_next;
    end
  end

  // Dwell timer: restarts on every state change, saturates at 255
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer <= 8'd0;
    end else if (w_next != r_state) begin
      r_timer <= 8'd0;
    end else if (r_timer != 8'hFF) begin
      r_timer <= r_timer + 8'd1;
    end
  end

  // Next-state logic. Green is given up only when the other road requests;
  // a request on the own road delays handover until the max-green limit.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_G1:    if (y && w_min_ok && (!x || w_max_ok)) w_next = S_Y1;
      S_Y1:    if (r_timer == C_YEL_M1)               w_next = S_AR1;
      S_AR1:   if (r_timer == C_AR_M1)                w_next = S_G2;
      S_G2:    if (x && w_min_ok && (!y || w_max_ok)) w_next = S_Y2;
      S_Y2:    if (r_timer == C_YEL_M1)               w_next = S_AR2;
      S_AR2:   if (r_timer == C_AR_M1)                w_next = S_G1;
      default:                                        w_next = S_G1;
    endcase
  end

  // Lamp decode. Unused encodings show the G1 pattern so the lamps always
  // satisfy the one-lamp-per-road rule while the FSM recovers.
  always_comb begin
    r1 = 1'b0;
    y1 = 1'b0;
    g1 = 1'b0;
    r2 = 1'b0;
    y2 = 1'b0;
    g2 = 1'b0;
    case (r_state)
      S_G1:    begin g1 = 1'b1; r2 = 1'b1; end
      S_Y1:    begin y1 = 1'b1; r2 = 1'b1; end
      S_AR1:   begin r1 = 1'b1; r2 = 1'b1; end
      S_G2:    begin r1 = 1'b1; g2 = 1'b1; end
      S_Y2:    begin r1 = 1'b1; y2 = 1'b1; end
      S_AR2:   begin r1 = 1'b1; r2 = 1'b1; end
      default: begin g1 = 1'b1; r2 = 1'b1; end
    endcase
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_tlc_using_sensor.sv
// -----------------------------------------------------------------------------
// tb_tlc_using_sensor
//   Self-checking bench for tlc_using_sensor (default parameters).
//   Lamps are packed as {r1,y1,g1,r2,y2,g2}.
// -----------------------------------------------------------------------------
module tb_tlc_using_sensor;

  localparam int MIN_GREEN   = 3;
  localparam int MAX_GREEN   = 6;
  localparam int YELLOW_TIME = 2;
  localparam int ALL_RED     = 1;

  localparam logic [5:0] L_G1 = 6'b001100;
  localparam logic [5:0] L_Y1 = 6'b010100;
  localparam logic [5:0] L_AR = 6'b100100;
  localparam logic [5:0] L_G2 = 6'b100001;
  localparam logic [5:0] L_Y2 = 6'b100010;

  logic       clk;
  logic       reset;
  logic       x;
  logic       y;
  logic       r1, y1, g1, r2, y2, g2;
  logic [2:0] dbg_state;
  logic [5:0] lamps;

  int n_total;
  int n_pass;

  // Reference model: phase index in the light cycle and cycles spent in it
  int m_phase;
  int m_dwell;

  tlc_using_sensor #(
    .MIN_GREEN  (MIN_GREEN),
    .MAX_GREEN  (MAX_GREEN),
    .YELLOW_TIME(YELLOW_TIME),
    .ALL_RED    (ALL_RED)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .x          (x),
    .y          (y),
    .r1         (r1),
    .y1         (y1),
    .g1         (g1),
    .r2         (r2),
    .y2         (y2),
    .g2         (g2),
    .o_dbg_state(dbg_state)
  );

  assign lamps = {r1, y1, g1, r2, y2, g2};

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [5:0] model_lamps(input int p);
    case (p)
      0:       return L_G1;
      1:       return L_Y1;
      2:       return L_AR;
      3:       return L_G2;
      4:       return L_Y2;
      default: return L_AR;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_dwell = 0;
  endtask

  // One clock edge of the light cycle, written from the timing rules:
  // green yields after MIN_GREEN cycles when the other road waits, unless the
  // own road also waits, in which case it yields after MAX_GREEN cycles.
  task automatic model_step(input bit xi, input bit yi);
    bit adv;
    bit own_req;
    bit other_req;
    own_req   = (m_phase == 0) ? xi : yi;
    other_req = (m_phase == 0) ? yi : xi;
    case (m_phase)
      0, 3:    adv = other_req && (m_dwell + 1 >= MIN_GREEN) &&
                     (!own_req || (m_dwell + 1 >= MAX_GREEN));
      1, 4:    adv = (m_dwell + 1 == YELLOW_TIME);
      default: adv = (m_dwell + 1 == ALL_RED);
    endcase
    if (adv) begin
      m_phase = (m_phase + 1) % 6;
      m_dwell = 0;
    end else if (m_dwell < 255) begin
      m_dwell = m_dwell + 1;
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the edge; outputs are read there too.
  task automatic tick(input bit xi, input bit yi);
    x = xi;
    y = yi;
    @(posedge clk);
    model_step(xi, yi);
    #1;
  endtask

  task automatic do_reset(input bit xi, input bit yi);
    x = xi;
    y = yi;
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    x = 1'b0;
    y = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    n_total++;
    if (lamps !== L_G1) $display("FAIL reset_immediate: got %b required %b", lamps, L_G1);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_total++;
      if (lamps !== L_G1) $display("FAIL reset_held[%0d]: got %b required %b", i, lamps, L_G1);
      else n_pass++;
    end
    reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick(1'b0, 1'b0);
      n_total++;
      if (lamps !== L_G1) $display("FAIL idle_hold[%0d]: got %b required %b", i, lamps, L_G1);
      else n_pass++;
    end
  endtask

  task automatic test_g1_to_g2();
    logic [5:0] exp_seq [4];
    exp_seq[0] = L_Y1;
    exp_seq[1] = L_Y1;
    exp_seq[2] = L_AR;
    exp_seq[3] = L_G2;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b1);
      n_total++;
      if (lamps !== exp_seq[i]) $display("FAIL g1_to_g2[%0d]: got %b required %b", i, lamps, exp_seq[i]);
      else n_pass++;
    end
  endtask

  task automatic test_g2_to_g1();
    logic [5:0] exp_seq [6];
    exp_seq[0] = L_G2;
    exp_seq[1] = L_G2;
    exp_seq[2] = L_Y2;
    exp_seq[3] = L_Y2;
    exp_seq[4] = L_AR;
    exp_seq[5] = L_G1;
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 1'b0);
      n_total++;
      if (lamps !== exp_seq[i]) $display("FAIL g2_to_g1[%0d]: got %b required %b", i, lamps, exp_seq[i]);
      else n_pass++;
    end
  endtask

  task automatic test_both_request();
    logic [5:0] exp_q [$];
    for (int r = 0; r < 2; r++) begin
      repeat (MAX_GREEN)   exp_q.push_back(L_G1);
      repeat (YELLOW_TIME) exp_q.push_back(L_Y1);
      repeat (ALL_RED)     exp_q.push_back(L_AR);
      repeat (MAX_GREEN)   exp_q.push_back(L_G2);
      repeat (YELLOW_TIME) exp_q.push_back(L_Y2);
      repeat (ALL_RED)     exp_q.push_back(L_AR);
    end
    do_reset(1'b1, 1'b1);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) tick(1'b1, 1'b1);
      n_total++;
      if (lamps !== exp_q[i]) $display("FAIL both_request[%0d]: got %b required %b", i, lamps, exp_q[i]);
      else n_pass++;
      n_total++;
      if ((g1 | y1) & (g2 | y2)) $display("FAIL both_conflict[%0d]: got %b required no conflict", i, lamps);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    logic [5:0] exp_seq [3];
    do_reset(1'b0, 1'b0);
    repeat (3) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    n_total++;
    if (lamps !== L_Y1) $display("FAIL async_pre_y1: got %b required %b", lamps, L_Y1);
    else n_pass++;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    n_total++;
    if (lamps !== L_G1) $display("FAIL async_reset_mid_y1: got %b required %b", lamps, L_G1);
    else n_pass++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    // Timer restarted: G1 must last MIN_GREEN cycles again before yielding
    exp_seq[0] = L_G1;
    exp_seq[1] = L_G1;
    exp_seq[2] = L_Y1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1);
      n_total++;
      if (lamps !== exp_seq[i]) $display("FAIL async_restart[%0d]: got %b required %b", i, lamps, exp_seq[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int         g_run [2];
    int         y_run [2];
    logic [5:0] exp_l;
    bit         xi, yi;
    do_reset(1'b0, 1'b0);
    g_run[0] = 0; g_run[1] = 0;
    y_run[0] = 0; y_run[1] = 0;
    for (int i = 0; i < 1000; i++) begin
      if (i > 0) begin
        xi = 1'($urandom_range(0, 1));
        yi = 1'($urandom_range(0, 1));
        tick(xi, yi);
      end
      exp_l = model_lamps(m_phase);
      n_total++;
      if (lamps !== exp_l) $display("FAIL rand_lamps[%0d]: got %b required %b", i, lamps, exp_l);
      else n_pass++;
      n_total++;
      if (!$onehot({r1, y1, g1})) $display("FAIL rand_onehot_road1[%0d]: got %b required one-hot", i, {r1, y1, g1});
      else n_pass++;
      n_total++;
      if (!$onehot({r2, y2, g2})) $display("FAIL rand_onehot_road2[%0d]: got %b required one-hot", i, {r2, y2, g2});
      else n_pass++;
      n_total++;
      if ((g1 & g2) | (g1 & y2) | (y1 & g2)) $display("FAIL rand_conflict[%0d]: got %b required no conflict", i, lamps);
      else n_pass++;
      // Phase duration bookkeeping from the observed lamps
      if (g1 === 1'b1) g_run[0]++;
      else if (g_run[0] > 0) begin
        n_total++;
        if (g_run[0] < MIN_GREEN) $display("FAIL rand_green1_len: got %0d required >= %0d", g_run[0], MIN_GREEN);
        else n_pass++;
        g_run[0] = 0;
      end
      if (g2 === 1'b1) g_run[1]++;
      else if (g_run[1] > 0) begin
        n_total++;
        if (g_run[1] < MIN_GREEN) $display("FAIL rand_green2_len: got %0d required >= %0d", g_run[1], MIN_GREEN);
        else n_pass++;
        g_run[1] = 0;
      end
      if (y1 === 1'b1) y_run[0]++;
      else if (y_run[0] > 0) begin
        n_total++;
        if (y_run[0] != YELLOW_TIME) $display("FAIL rand_yellow1_len: got %0d required %0d", y_run[0], YELLOW_TIME);
        else n_pass++;
        y_run[0] = 0;
      end
      if (y2 === 1'b1) y_run[1]++;
      else if (y_run[1] > 0) begin
        n_total++;
        if (y_run[1] != YELLOW_TIME) $display("FAIL rand_yellow2_len: got %0d required %0d", y_run[1], YELLOW_TIME);
        else n_pass++;
        y_run[1] = 0;
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_total = 0;
    n_pass  = 0;
    reset   = 1'b0;
    x       = 1'b0;
    y       = 1'b0;
    model_reset();
    test_reset();
    test_g1_to_g2();
    test_g2_to_g1();
    test_both_request();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
